testeio_done_handshake: RTL and testbench

TESTEIO_DONE_HANDSHAKE -- requirements
Module: testeio_done_handshake

---
 rtl/testeio_done_handshake.sv | 167 ++++++++++++++++
 tb/tb_testeio_done_handshake.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/testeio_done_handshake.sv
// Done-level handshake between a serial loader and a software PIO, with Avalon-MM status/control.
// Optional watchdog is compiled in when TESTEIO_DONE_TIMEOUT_EN is defined.
module testeio_done_handshake #(
    parameter int TO_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        done_feedback,
    input  logic        req_valid,
    output logic        req_ready,
    output logic        data_ready,
    output logic        ack,
    output logic        timeout,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             done_q;
    logic             rise;
    logic             wr;
    logic             wr_clr_cnt;
    logic             wr_abort;
    logic             to_hit;
    logic             ack_nxt;
    logic [CNT_W-1:0] count;
    logic [31:0]      limit_rd;
    logic             unused_wd;

    assign rise       = done_feedback & ~done_q;
    assign wr         = chipselect & ~write_n;
    assign wr_clr_cnt = wr && (address == 2'd1);
    assign wr_abort   = wr && (address == 2'd3) && writedata[0];
    assign unused_wd  = ^writedata;

    assign req_ready  = (state == IDLE) && !done_feedback;
    assign data_ready = (state == WAIT_HI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_feedback;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            ack   <= ack_nxt;
        end
    end

    // Abort overrides everything, including a rise seen in the same cycle.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (to_hit) begin
                    state_nxt = IDLE;
                end else if (rise) begin
                    state_nxt = WAIT_LO;
                    ack_nxt   = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!done_feedback) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (wr_abort) begin
            state_nxt = IDLE;
            ack_nxt   = 1'b0;
        end
    end

    // A software clear beats a completion landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (wr_clr_cnt) begin
            count <= '0;
        end else if (ack_nxt) begin
            count <= count + CNT_W'(1);
        end
    end

`ifdef TESTEIO_DONE_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_limit;
    logic            wr_clr_to;
    logic            wr_limit;

    assign wr_clr_to = wr && (address == 2'd0) && writedata[1];
    assign wr_limit  = wr && (address == 2'd2);
    assign to_hit    = (state == WAIT_HI) && (to_cnt == to_limit);
    assign limit_rd  = 32'(to_limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if ((state == WAIT_HI) && (state_nxt == WAIT_HI)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_limit <= '1;
        end else if (wr_limit) begin
            to_limit <= writedata[TO_W-1:0];
        end
    end

    // A new expiry wins over a clear issued in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout <= 1'b0;
        end else if (to_hit) begin
            timeout <= 1'b1;
        end else if (wr_clr_to) begin
            timeout <= 1'b0;
        end
    end
`else
    assign to_hit   = 1'b0;
    assign timeout  = 1'b0;
    assign limit_rd = 32'd0;
`endif

    always_comb begin
        readdata = 32'd0;
        unique case (address)
            2'd0: readdata = {27'b0, state, timeout, req_ready, data_ready};
            2'd1: readdata = 32'(count);
            2'd2: readdata = limit_rd;
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_testeio_done_handshake.sv
// Directed and randomized checks of testeio_done_handshake against a transaction-level model.
// A second, narrow-counter instance shares all inputs so counter wrap is reachable quickly.
module tb_testeio_done_handshake;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        done_feedback = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        data_ready;
    logic        ack;
    logic        timeout;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        req_ready_w;
    logic        data_ready_w;
    logic        ack_w;
    logic        timeout_w;
    logic [31:0] readdata_w;

    int          errors = 0;
    int          checks = 0;
    int          completions = 0;
    logic [31:0] rdata;
    logic [31:0] rdata_w;
    logic [31:0] lim_rst;

    always #5 clk = ~clk;

    testeio_done_handshake dut (
        .clk(clk), .reset_n(reset_n), .done_feedback(done_feedback),
        .req_valid(req_valid), .req_ready(req_ready), .data_ready(data_ready),
        .ack(ack), .timeout(timeout), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata)
    );

    testeio_done_handshake #(.TO_W(16), .CNT_W(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .done_feedback(done_feedback),
        .req_valid(req_valid), .req_ready(req_ready_w), .data_ready(data_ready_w),
        .ack(ack_w), .timeout(timeout_w), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Status word as software sees it: phase, sticky flag, and the two handshake levels.
    function automatic logic [31:0] st(input int phase, input bit to, input bit rr, input bit dr);
        return 32'(phase * 8 + (to ? 4 : 0) + (rr ? 2 : 0) + (dr ? 1 : 0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        #1;
        rdata   = readdata;
        rdata_w = readdata_w;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic txn(input int hi_wait, input int lo_hold);
        int n = 0;
        req_valid = 1'b1;
        #1;
        while (!req_ready && n < 8) begin
            tick();
            n++;
        end
        chk("txn_accept", 32'(n < 8), 1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < hi_wait; i++) begin
            chk("txn_data_ready", data_ready, 1);
            chk("txn_no_early_ack", ack, 0);
            tick();
        end
        chk("txn_data_ready_last", data_ready, 1);
        done_feedback = 1'b1;
        tick();
        chk("txn_ack", ack, 1);
        completions++;
        rd(2'd1);
        chk("txn_count", rdata, 32'(completions % 65536));
        chk("txn_count_w4", rdata_w, 32'(completions % 16));
        for (int i = 0; i <= lo_hold; i++) begin
            tick();
            chk("txn_ack_once", ack, 0);
            chk("txn_lo_not_ready", req_ready, 0);
        end
        done_feedback = 1'b0;
        tick();
        chk("txn_back_idle", req_ready, 1);
    endtask

    initial begin
`ifdef TESTEIO_DONE_TIMEOUT_EN
        lim_rst = 32'h0000_ffff;
`else
        lim_rst = 32'h0;
`endif
        #2;
        chk("rst_ack", ack, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_timeout", timeout, 0);
        rd(2'd0);
        chk("rst_status", rdata, st(0, 0, 1, 0));
        rd(2'd1);
        chk("rst_count", rdata, 0);
        rd(2'd2);
        chk("rst_limit", rdata, lim_rst);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // First transaction: acceptance, one-cycle ack, count readback
        req_valid = 1'b1;
        #1;
        chk("first_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("first_data_ready", data_ready, 1);
        rd(2'd0);
        chk("first_status_hi", rdata, st(1, 0, 0, 1));
        done_feedback = 1'b1;
        #1;
        chk("first_ack_not_yet", ack, 0);
        tick();
        chk("first_ack", ack, 1);
        rd(2'd1);
        chk("first_count", rdata, 1);
        rd(2'd0);
        chk("first_status_lo", rdata, st(2, 0, 0, 0));
        tick();
        chk("first_ack_width", ack, 0);
        done_feedback = 1'b0;
        tick();
        rd(2'd0);
        chk("first_idle", rdata, st(0, 0, 1, 0));
        completions = 1;

        // done held high in IDLE blocks acceptance
        done_feedback = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("busy_req_ready", req_ready, 0);
        repeat (3) tick();
        rd(2'd0);
        chk("busy_hold", rdata, st(0, 0, 0, 0));
        done_feedback = 1'b0;
        #1;
        chk("busy_release", req_ready, 1);
        tick();
        req_valid = 1'b0;
        rd(2'd0);
        chk("busy_accept", rdata, st(1, 0, 0, 1));
        done_feedback = 1'b1;
        tick();
        chk("busy_ack", ack, 1);
        completions++;
        tick();
        done_feedback = 1'b0;
        tick();

        // Count clear coinciding with a rise: ack still fires, count ends at zero
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        done_feedback = 1'b1;
        wr(2'd1, $urandom);
        chk("clr_rise_ack", ack, 1);
        rd(2'd1);
        chk("clr_rise_count", rdata, 0);
        completions = 0;
        tick();
        done_feedback = 1'b0;
        tick();

        // Abort coinciding with a rise: no ack, count untouched
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        done_feedback = 1'b1;
        wr(2'd3, 32'h1);
        chk("abort_no_ack", ack, 0);
        rd(2'd0);
        chk("abort_status", rdata, st(0, 0, 0, 0));
        rd(2'd1);
        chk("abort_count", rdata, 32'(completions));
        tick();
        chk("abort_no_late_ack", ack, 0);
        done_feedback = 1'b0;
        tick();

        // Randomized transactions; the 4-bit instance wraps after 16
        for (int t = 0; t < 20; t++) begin
            txn($urandom_range(0, 6), $urandom_range(0, 3));
        end

`ifdef TESTEIO_DONE_TIMEOUT_EN
        wr(2'd2, 32'd10);
        rd(2'd2);
        chk("to_limit_rd", rdata, 10);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("to_waiting", data_ready, 1);
            chk("to_not_yet", timeout, 0);
            tick();
        end
        chk("to_last_hi", data_ready, 1);
        tick();
        chk("to_flag", timeout, 1);
        chk("to_no_ack", ack, 0);
        rd(2'd0);
        chk("to_status", rdata, st(0, 1, 1, 0));
        rd(2'd1);
        chk("to_count", rdata, 32'(completions % 65536));
        wr(2'd0, 32'h2);
        chk("to_cleared", timeout, 0);
        wr(2'd2, 32'hffff);
`else
        wr(2'd2, 32'h1234);
        rd(2'd2);
        chk("nolimit_rd", rdata, 0);
        chk("nolimit_timeout", timeout, 0);
`endif

        // Reset in WAIT_HI drops the word with no ack
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_hi_data_ready", data_ready, 0);
        reset_n = 1'b1;
        completions = 0;
        done_feedback = 1'b1;
        tick();
        chk("rst_hi_no_ack", ack, 0);
        tick();
        chk("rst_hi_no_ack2", ack, 0);
        done_feedback = 1'b0;
        tick();

        // Reset in WAIT_LO clears outputs asynchronously
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        done_feedback = 1'b1;
        tick();
        chk("rst_lo_ack_before", ack, 1);
        reset_n = 1'b0;
        rd(2'd0);
        chk("rst_lo_status", rdata, 0);
        chk("rst_lo_ack", ack, 0);
        chk("rst_lo_req_ready", req_ready, 0);
        rd(2'd1);
        chk("rst_lo_count", rdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        done_feedback = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
